arith_microop_arbiter: RTL and testbench
========================================

ARITH_MICROOP_ARBITER -- requirements
Module: arith_microop_arbiter

Interface
REQ-001 Parameter: LATENCY, 1, clock cycles from driving alu_* operands until alu_data is valid (legal range 1..7).
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_op  input  3  requester 0 operation code {s[1:0], carry}.
REQ-006 req0_a, req0_b  input  4 each  requester 0 signed operands.
REQ-007 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-008 req1_valid, req1_op, req1_a, req1_b, req1_ready  same widths/directions as requester 0, for requester 1.
REQ-009 alu_s  output  2  select to shared arithmetic datapath.
REQ-010 alu_carry  output  1  carry-in to datapath.
REQ-011 alu_a, alu_b  output  4 each  signed operands to datapath.
REQ-012 alu_data  input  5  signed datapath result.
REQ-013 rsp_valid  output  1  result available.
REQ-014 rsp_id  output  1  requester index owning the result.
REQ-015 rsp_data  output  5  signed captured result.
REQ-016 rsp_ready  input  1  consumer accepts result.

Function
REQ-017 FSM states: IDLE, EXEC, RESP; one operation in flight at most.
REQ-018 IDLE: if any reqN_valid, grant one requester, pulse its reqN_ready for exactly that cycle, latch op/a/b/id into hold registers, load cycle counter with LATENCY, go EXEC; else stay IDLE.
REQ-019 reqN_ready is asserted only in IDLE and only for the granted requester; never for both in one cycle.
REQ-020 EXEC: alu_s/alu_carry/alu_a/alu_b driven from hold registers every cycle; counter decrements each cycle; on the cycle counter reaches 0, alu_data is captured into rsp_data and state goes RESP.
REQ-021 Total accept-to-rsp_valid latency is LATENCY+1 cycles.
REQ-022 IDLE and RESP: alu_s, alu_carry, alu_a, alu_b driven to 0.
REQ-023 RESP: rsp_valid=1, rsp_id and rsp_data stable until the cycle rsp_ready=1; that cycle completes the transfer and state returns IDLE.
REQ-024 No grant in the cycle a response completes; next grant earliest in the following cycle (IDLE).
REQ-025 rsp_data is captured as-is (5-bit signed, no saturation or sign manipulation).
REQ-026 Requester inputs are ignored outside the IDLE grant cycle; deasserting reqN_valid while not granted is legal and discards nothing.
REQ-027 last_grant register records index of each grant, updated in IDLE grant cycle.

Reset
REQ-028 reset=1 at a rising edge forces IDLE from any state, abandoning any in-flight operation with no response.
REQ-029 Reset values: req0_ready=0, req1_ready=0, alu_s=0, alu_carry=0, alu_a=0, alu_b=0, rsp_valid=0, rsp_id=0, rsp_data=0, counter=0, last_grant=1.
REQ-030 No grant occurs in a cycle where reset=1.

Configuration
REQ-031 Macro ARB_ROUND_ROBIN_EN defined: when both valid in IDLE, grant the requester not equal to last_grant (first contention after reset goes to requester 0).
REQ-032 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins contention; last_grant still maintained but unused.
REQ-033 Single-requester behaviour identical in both builds.

Verification (bench connects real arithmetic datapath, LATENCY=1)
REQ-034 Reset held 2 cycles mid-EXEC -> next cycle state IDLE, all outputs 0, no rsp_valid ever for abandoned op.
REQ-035 req0 only, op=000, a=5, b=-3 -> req0_ready pulse 1 cycle, rsp_valid 2 cycles later, rsp_id=0, rsp_data=2.
REQ-036 Both valid continuously, rsp_ready=1, ARB_ROUND_ROBIN_EN defined -> grants alternate 0,1,0,1; undefined -> grants 0,0,0,0.
REQ-037 rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_id/rsp_data held constant, no reqN_ready asserted; release -> IDLE next cycle.
REQ-038 req1 op=001, a=7, b=7 (A+B+1) -> rsp_id=1, rsp_data=15, no 4-bit wrap in result.

Source files
------------

// File: rtl/arith_microop_arbiter.sv
// Two-requester arbiter in front of a shared multi-cycle arithmetic datapath.
// Optional build macro ARB_ROUND_ROBIN_EN selects round-robin contention (default: requester 0 wins).
module arith_microop_arbiter #(
  parameter int unsigned LATENCY = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [2:0] req0_op,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [2:0] req1_op,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       req1_ready,
  output logic [1:0] alu_s,
  output logic       alu_carry,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [4:0] alu_data,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [4:0] rsp_data,
  input  logic       rsp_ready,
  output logic [1:0] dbg_state,
  output logic       dbg_last_grant
);

  // Handshake: a requester transfers in the cycle its valid and ready are both high;
  // the response transfers in the cycle rsp_valid and rsp_ready are both high.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] LOAD_CNT = 3'(LATENCY);

  state_t     state;
  state_t     state_next;
  logic [2:0] cnt;
  logic [2:0] hold_op;
  logic [3:0] hold_a;
  logic [3:0] hold_b;
  logic       hold_id;
  logic       last_grant;
  logic       grant_any;
  logic       grant_id;

  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (state == IDLE && !reset) begin
      grant_any = req0_valid | req1_valid;
      if (req0_valid && req1_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
        grant_id = ~last_grant;
`else
        grant_id = 1'b0;
`endif
      end else begin
        grant_id = req1_valid;
      end
    end
  end

  always_comb begin
    state_next = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    alu_s      = 2'd0;
    alu_carry  = 1'b0;
    alu_a      = 4'd0;
    alu_b      = 4'd0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          state_next = EXEC;
          req0_ready = ~grant_id;
          req1_ready = grant_id;
        end
      end
      EXEC: begin
        alu_s     = hold_op[2:1];
        alu_carry = hold_op[0];
        alu_a     = hold_a;
        alu_b     = hold_b;
        if (cnt <= 3'd1) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      hold_op    <= 3'd0;
      hold_a     <= 4'd0;
      hold_b     <= 4'd0;
      hold_id    <= 1'b0;
      last_grant <= 1'b1;
      rsp_id     <= 1'b0;
      rsp_data   <= 5'd0;
    end else begin
      state <= state_next;
      if (grant_any) begin
        hold_op    <= grant_id ? req1_op : req0_op;
        hold_a     <= grant_id ? req1_a  : req0_a;
        hold_b     <= grant_id ? req1_b  : req0_b;
        hold_id    <= grant_id;
        last_grant <= grant_id;
        cnt        <= LOAD_CNT;
      end
      if (state == EXEC) begin
        cnt <= cnt - 3'd1;
        // The cycle the counter reaches zero is the cycle alu_data is valid.
        if (cnt <= 3'd1) begin
          rsp_data <= alu_data;
          rsp_id   <= hold_id;
        end
      end
    end
  end

  assign rsp_valid      = (state == RESP);
  assign dbg_state      = state;
  assign dbg_last_grant = last_grant;

endmodule

// File: tb/tb_arith_microop_arbiter.sv
// Bench for arith_microop_arbiter with a combinational arithmetic datapath (LATENCY=1).
// Honours ARB_ROUND_ROBIN_EN when computing contention expectations.
module tb_arith_microop_arbiter;
  localparam int LAT = 1;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [2:0] req0_op, req1_op;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready;
  logic [1:0] alu_s;
  logic       alu_carry;
  logic [3:0] alu_a, alu_b;
  logic [4:0] alu_data;
  logic       rsp_valid, rsp_id, rsp_ready;
  logic [4:0] rsp_data;
  logic [1:0] dbg_state;
  logic       dbg_last_grant;

  int checks = 0;
  int failures = 0;
  logic [5:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Datapath: s=0 A+B+c, s=1 A-B-1+c, s=2 A+c, s=3 B-A-1+c (signed, 5-bit result).
  function automatic logic [4:0] dp(input logic [1:0] s, input logic c,
                                    input logic [3:0] a, input logic [3:0] b);
    int ai, bi, r;
    ai = int'($signed(a));
    bi = int'($signed(b));
    case (s)
      2'd0:    r = ai + bi + int'(c);
      2'd1:    r = ai - bi - 1 + int'(c);
      2'd2:    r = ai + int'(c);
      default: r = bi - ai - 1 + int'(c);
    endcase
    return r[4:0];
  endfunction

  assign alu_data = dp(alu_s, alu_carry, alu_a, alu_b);

  arith_microop_arbiter #(.LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ready(req1_ready),
    .alu_s(alu_s), .alu_carry(alu_carry), .alu_a(alu_a), .alu_b(alu_b),
    .alu_data(alu_data),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .dbg_state(dbg_state), .dbg_last_grant(dbg_last_grant)
  );

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    req0_valid = 1'b0; req0_op = 3'd0; req0_a = 4'd0; req0_b = 4'd0;
    req1_valid = 1'b0; req1_op = 3'd0; req1_a = 4'd0; req1_b = 4'd0;
    rsp_ready  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock); #1;
      checks++; if ({req0_ready, req1_ready} !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready}); end
    end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if ({alu_s, alu_carry, alu_a, alu_b} !== 11'd0) begin failures++; $display("FAIL reset_alu got=%h exp=0", {alu_s, alu_carry, alu_a, alu_b}); end
    checks++; if ({rsp_id, rsp_data} !== 6'd0) begin failures++; $display("FAIL reset_rsp got=%h exp=0", {rsp_id, rsp_data}); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    checks++; if (dbg_last_grant !== 1'b1) begin failures++; $display("FAIL reset_last_grant got=%b exp=1", dbg_last_grant); end
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_single();
    do_reset();
    req0_valid = 1'b1; req0_op = 3'b000; req0_a = 4'd5; req0_b = 4'hD; rsp_ready = 1'b1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin failures++; $display("FAIL single_grant got=%b exp=10", {req0_ready, req1_ready}); end
    @(negedge clock); req0_valid = 1'b0; #1;
    checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL single_ready_pulse got=%b exp=0", req0_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_early_rsp got=%b exp=0", rsp_valid); end
    checks++; if ({alu_s, alu_carry, alu_a, alu_b} !== {2'd0, 1'b0, 4'd5, 4'hD}) begin failures++; $display("FAIL single_alu got=%h exp=%h", {alu_s, alu_carry, alu_a, alu_b}, {2'd0, 1'b0, 4'd5, 4'hD}); end
    @(negedge clock); #1;
    checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 5'd2}) begin failures++; $display("FAIL single_rsp got=%h exp=%h", {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b0, 5'd2}); end
    checks++; if ({alu_s, alu_carry, alu_a, alu_b} !== 11'd0) begin failures++; $display("FAIL single_alu_resp got=%h exp=0", {alu_s, alu_carry, alu_a, alu_b}); end
    @(negedge clock); #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_rsp_done got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_carry();
    do_reset();
    req1_valid = 1'b1; req1_op = 3'b001; req1_a = 4'd7; req1_b = 4'd7; rsp_ready = 1'b1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin failures++; $display("FAIL carry_grant got=%b exp=01", {req0_ready, req1_ready}); end
    @(negedge clock); req1_valid = 1'b0;
    @(negedge clock); #1;
    checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, 5'd15}) begin failures++; $display("FAIL carry_rsp got=%h exp=%h", {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b1, 5'd15}); end
    checks++; if (dbg_last_grant !== 1'b1) begin failures++; $display("FAIL carry_last_grant got=%b exp=1", dbg_last_grant); end
  endtask

  task automatic test_hold();
    do_reset();
    req0_valid = 1'b1; req0_op = 3'b010; req0_a = 4'd3; req0_b = 4'hE;
    #1;
    checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL hold_grant got=%b exp=1", req0_ready); end
    @(negedge clock);
    req0_op = 3'b111; req0_a = 4'd1; req0_b = 4'd2;
    req1_valid = 1'b1; req1_op = 3'b100; req1_a = 4'd6; req1_b = 4'd1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock); #1;
      checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 5'd4}) begin failures++; $display("FAIL hold_rsp cyc=%0d got=%h exp=%h", k, {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b0, 5'd4}); end
      checks++; if ({req0_ready, req1_ready} !== 2'b00) begin failures++; $display("FAIL hold_ready cyc=%0d got=%b exp=00", k, {req0_ready, req1_ready}); end
    end
    @(negedge clock); rsp_ready = 1'b1; #1;
    checks++; if ({rsp_valid, req0_ready, req1_ready} !== 3'b100) begin failures++; $display("FAIL hold_release got=%b exp=100", {rsp_valid, req0_ready, req1_ready}); end
    @(negedge clock); rsp_ready = 1'b0; #1;
    checks++; if ({rsp_valid, req0_ready, req1_ready} !== {1'b0, !RR, RR}) begin failures++; $display("FAIL hold_next_grant got=%b exp=%b", {rsp_valid, req0_ready, req1_ready}, {1'b0, !RR, RR}); end
  endtask

  task automatic test_back_to_back();
    int gid[4];
    int gcyc[4];
    int n = 0;
    bit both = 1'b0;
    do_reset();
    req0_valid = 1'b1; req0_op = 3'b000; req0_a = 4'd1; req0_b = 4'd1;
    req1_valid = 1'b1; req1_op = 3'b011; req1_a = 4'd2; req1_b = 4'd5;
    rsp_ready = 1'b1;
    for (int c = 0; c < 40 && n < 4; c++) begin
      if (c != 0) @(negedge clock);
      #1;
      if (req0_ready && req1_ready) both = 1'b1;
      if (req0_ready || req1_ready) begin
        gid[n] = req1_ready ? 1 : 0;
        gcyc[n] = c;
        n++;
      end
    end
    checks++; if (n !== 4) begin failures++; $display("FAIL b2b_grant_count got=%0d exp=4", n); end
    checks++; if (both !== 1'b0) begin failures++; $display("FAIL b2b_both_ready got=%b exp=0", both); end
    for (int i = 0; i < n; i++) begin
      checks++; if (gid[i] !== (RR ? i % 2 : 0)) begin failures++; $display("FAIL b2b_grant%0d got=%0d exp=%0d", i, gid[i], RR ? i % 2 : 0); end
      if (i > 0) begin
        checks++; if (gcyc[i] - gcyc[i-1] !== LAT + 2) begin failures++; $display("FAIL b2b_spacing%0d got=%0d exp=%0d", i, gcyc[i] - gcyc[i-1], LAT + 2); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_exec();
    do_reset();
    req0_valid = 1'b1; req0_op = 3'b001; req0_a = 4'd4; req0_b = 4'd2; rsp_ready = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL midrst_grant got=%b exp=1", req0_ready); end
    @(negedge clock); req0_valid = 1'b0; reset = 1'b1;
    @(negedge clock); #1;
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL midrst_state got=%0d exp=0", dbg_state); end
    checks++; if ({rsp_valid, rsp_id, rsp_data, req0_ready, req1_ready} !== 8'd0) begin failures++; $display("FAIL midrst_outputs got=%h exp=0", {rsp_valid, rsp_id, rsp_data, req0_ready, req1_ready}); end
    checks++; if ({alu_s, alu_carry, alu_a, alu_b} !== 11'd0) begin failures++; $display("FAIL midrst_alu got=%h exp=0", {alu_s, alu_carry, alu_a, alu_b}); end
    @(negedge clock); reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL midrst_no_rsp cyc=%0d got=%b exp=0", k, rsp_valid); end
      @(negedge clock);
    end
  endtask

  // ---------------- randomized run against a transaction-level model ----------------
  task automatic test_random();
    bit         p_valid[2];
    logic [2:0] p_op[2];
    logic [3:0] p_a[2], p_b[2];
    bit         busy = 1'b0;
    logic       m_last = 1'b1;
    int         acc = 0;
    logic [10:0] h_alu = 11'd0;
    int         gid;
    bit         in_exec;
    logic [1:0] exp_rdy;
    do_reset();
    exp_q.delete();
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (cyc != 0) @(negedge clock);
      for (int i = 0; i < 2; i++) begin
        if (!p_valid[i] && $urandom_range(0, 2) == 0) begin
          p_valid[i] = 1'b1;
          p_op[i] = 3'($urandom_range(0, 7));
          p_a[i] = 4'($urandom_range(0, 15));
          p_b[i] = 4'($urandom_range(0, 15));
        end else if (p_valid[i] && !busy && $urandom_range(0, 15) == 0) begin
          p_valid[i] = 1'b0;
        end
      end
      req0_valid = p_valid[0];
      req0_op = p_valid[0] ? p_op[0] : 3'($urandom_range(0, 7));
      req0_a  = p_valid[0] ? p_a[0]  : 4'($urandom_range(0, 15));
      req0_b  = p_valid[0] ? p_b[0]  : 4'($urandom_range(0, 15));
      req1_valid = p_valid[1];
      req1_op = p_valid[1] ? p_op[1] : 3'($urandom_range(0, 7));
      req1_a  = p_valid[1] ? p_a[1]  : 4'($urandom_range(0, 15));
      req1_b  = p_valid[1] ? p_b[1]  : 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 2) != 0);
      #1;
      checks++; if (dbg_last_grant !== m_last) begin failures++; $display("FAIL rnd_last_grant cyc=%0d got=%b exp=%b", cyc, dbg_last_grant, m_last); end
      if (!busy) begin
        exp_rdy = 2'b00;
        gid = -1;
        if (p_valid[0] || p_valid[1]) begin
          if (p_valid[0] && p_valid[1]) gid = RR ? int'(!m_last) : 0;
          else gid = p_valid[1] ? 1 : 0;
          exp_rdy = (gid == 1) ? 2'b01 : 2'b10;
        end
        checks++; if ({req0_ready, req1_ready, rsp_valid} !== {exp_rdy, 1'b0}) begin failures++; $display("FAIL rnd_idle cyc=%0d got=%b exp=%b", cyc, {req0_ready, req1_ready, rsp_valid}, {exp_rdy, 1'b0}); end
        if (gid >= 0) begin
          exp_q.push_back({1'(gid), dp(p_op[gid][2:1], p_op[gid][0], p_a[gid], p_b[gid])});
          h_alu = {p_op[gid], p_a[gid], p_b[gid]};
          m_last = 1'(gid);
          acc = cyc;
          busy = 1'b1;
          p_valid[gid] = 1'b0;
        end
      end else begin
        in_exec = (cyc <= acc + LAT);
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin failures++; $display("FAIL rnd_busy_ready cyc=%0d got=%b exp=00", cyc, {req0_ready, req1_ready}); end
        checks++; if (rsp_valid !== !in_exec) begin failures++; $display("FAIL rnd_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, !in_exec); end
        checks++; if ({alu_s, alu_carry, alu_a, alu_b} !== (in_exec ? h_alu : 11'd0)) begin failures++; $display("FAIL rnd_alu cyc=%0d got=%h exp=%h", cyc, {alu_s, alu_carry, alu_a, alu_b}, in_exec ? h_alu : 11'd0); end
        if (!in_exec && exp_q.size() > 0) begin
          checks++; if ({rsp_id, rsp_data} !== exp_q[0]) begin failures++; $display("FAIL rnd_rsp_data cyc=%0d got=%h exp=%h", cyc, {rsp_id, rsp_data}, exp_q[0]); end
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            busy = 1'b0;
          end
        end
      end
    end
    idle_inputs();
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_single();
    test_carry();
    test_hold();
    test_back_to_back();
    test_reset_mid_exec();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
